// File: rtl/mem_io_ctrl.sv
// SLC-3 memory/IO controller: request/ready front end, multi-cycle SRAM sequencer
// with wait states and byte lanes, plus one memory-mapped IO word (switches / hex display).
module mem_io_ctrl #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 20,
    parameter int unsigned       WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = {ADDR_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [DATA_W/8-1:0]       be_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      ready_o,
    output logic                      busy_o,
    input  logic [DATA_W-1:0]         switches_i,
    output logic [7*(DATA_W/4)-1:0]   hex_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_dout_o,
    output logic                      mem_dout_en_o,
    input  logic [DATA_W-1:0]         mem_din_i,
    output logic                      mem_ce_o,
    output logic                      mem_oe_o,
    output logic                      mem_we_o,
    output logic                      mem_ub_o,
    output logic                      mem_lb_o
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned NUM_HEX = DATA_W / 4;
    localparam int unsigned SEG_W   = 7 * NUM_HEX;
    localparam int unsigned CNT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned UB_LANE = (BE_W > 1) ? 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_IO_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   hex_q, hex_d;
    logic [SEG_W-1:0]    hex_seg_q, hex_seg_d;
    logic [DATA_W-1:0]   sync1_q, sync2_q;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                ce_q, ce_d;
    logic                oe_q, oe_d;
    logic                mwe_q, mwe_d;
    logic                ub_q, ub_d;
    logic                lb_q, lb_d;
    logic                den_q, den_d;
    logic                mem_act;
    logic                io_hit;

    // Expand byte enables to a per-bit mask.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Active-low seven-segment pattern, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            rdata_q   <= '0;
            hex_q     <= '0;
            hex_seg_q <= {NUM_HEX{7'b1000000}};
            sync1_q   <= '0;
            sync2_q   <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            mwe_q     <= 1'b1;
            ub_q      <= 1'b1;
            lb_q      <= 1'b1;
            den_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            hex_q     <= hex_d;
            hex_seg_q <= hex_seg_d;
            sync1_q   <= switches_i;
            sync2_q   <= sync1_q;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            ce_q      <= ce_d;
            oe_q      <= oe_d;
            mwe_q     <= mwe_d;
            ub_q      <= ub_d;
            lb_q      <= lb_d;
            den_q     <= den_d;
        end
    end

    // Next state, transaction latches, and strobes decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        io_hit  = (addr_i == IO_ADDR);

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (io_hit || (be_i == '0)) begin
                        state_d = S_IO_DONE;
                        if (io_hit && we_i) begin
                            hex_d = (hex_q & ~lane_mask(be_i)) | (wdata_i & lane_mask(be_i));
                        end else if (io_hit) begin
                            rdata_d = sync2_q & lane_mask(be_i);
                        end
                    end else begin
                        state_d = S_SETUP;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        we_d    = we_i;
                        be_d    = be_i;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_W'(WAIT_STATES);
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = mem_din_i & lane_mask(be_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:    state_d = S_IDLE;
            S_IO_DONE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        mem_act = (state_d == S_SETUP) || (state_d == S_ACCESS);
        ce_d    = !mem_act;
        oe_d    = !(mem_act && !we_d);
        mwe_d   = !((state_d == S_ACCESS) && we_d);
        ub_d    = !(mem_act && be_d[UB_LANE]);
        lb_d    = !(mem_act && be_d[0]);
        den_d   = we_d && (mem_act || (state_d == S_DONE));
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_q == S_DONE) || (state_q == S_IO_DONE);

        hex_seg_d = '0;
        for (int i = 0; i < NUM_HEX; i++) begin
            hex_seg_d[7*i +: 7] = seg7(hex_d[4*i +: 4]);
        end
    end

    assign rdata_o       = rdata_q;
    assign ready_o       = ready_q;
    assign busy_o        = busy_q;
    assign hex_o         = hex_seg_q;
    assign mem_addr_o    = addr_q;
    assign mem_dout_o    = wdata_q;
    assign mem_dout_en_o = den_q;
    assign mem_ce_o      = ce_q;
    assign mem_oe_o      = oe_q;
    assign mem_we_o      = mwe_q;
    assign mem_ub_o      = ub_q;
    assign mem_lb_o      = lb_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Testbench for mem_io_ctrl: directed scenarios plus randomized transactions checked
// against a word-level model of memory contents, hex register and read data.
module tb_mem_io_ctrl;

    localparam int unsigned WS = 2;
    localparam logic [19:0] IOA = 20'hFFFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [19:0] addr = '0;
    logic [15:0] wdata = '0, switches = '0;
    logic [15:0] mem_din;

    logic [15:0] rdata, mem_dout;
    logic        ready, busy, mem_den, mem_ce, mem_oe, mem_we, mem_ub, mem_lb;
    logic [27:0] hex;
    logic [19:0] mem_addr;

    logic [15:0] z_rdata, z_mem_dout;
    logic        z_ready, z_busy, z_mem_den, z_mem_ce, z_mem_oe, z_mem_we, z_mem_ub, z_mem_lb;
    logic [27:0] z_hex;
    logic [19:0] z_mem_addr;

    mem_io_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready), .busy_o(busy),
        .switches_i(switches), .hex_o(hex), .mem_addr_o(mem_addr), .mem_dout_o(mem_dout),
        .mem_dout_en_o(mem_den), .mem_din_i(mem_din), .mem_ce_o(mem_ce), .mem_oe_o(mem_oe),
        .mem_we_o(mem_we), .mem_ub_o(mem_ub), .mem_lb_o(mem_lb)
    );

    mem_io_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(z_rdata), .ready_o(z_ready), .busy_o(z_busy),
        .switches_i(switches), .hex_o(z_hex), .mem_addr_o(z_mem_addr), .mem_dout_o(z_mem_dout),
        .mem_dout_en_o(z_mem_den), .mem_din_i(mem_din), .mem_ce_o(z_mem_ce), .mem_oe_o(z_mem_oe),
        .mem_we_o(z_mem_we), .mem_ub_o(z_mem_ub), .mem_lb_o(z_mem_lb)
    );

    // Simple asynchronous SRAM driven only by the WAIT_STATES=2 instance.
    logic [15:0] sram [64] = '{default: 16'h0000};
    assign mem_din = sram[mem_addr[5:0]];
    always @(posedge clk) begin
        if (!mem_ce && !mem_we) begin
            if (!mem_lb) sram[mem_addr[5:0]][7:0]  <= mem_dout[7:0];
            if (!mem_ub) sram[mem_addr[5:0]][15:8] <= mem_dout[15:8];
        end
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_mem [64] = '{default: 16'h0000};
    logic [15:0] hex_model = '0;
    logic [15:0] exp_rdata = '0;
    logic [6:0]  SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic logic [27:0] exp_hex(input logic [15:0] h);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = SEG[h[4*i +: 4]];
        return r;
    endfunction

    function automatic logic [15:0] mask_of(input logic [1:0] b);
        return {(b[1] ? 8'hFF : 8'h00), (b[0] ? 8'hFF : 8'h00)};
    endfunction

    // One-cycle request, then observe 12 cycles; latency counted in edges after sampling.
    task automatic run_txn(input logic w, input logic [1:0] b, input logic [19:0] a,
                           input logic [15:0] d, output int lat, output int zlat,
                           output int n_ce, output int n_oe, output int n_we, output int n_ub,
                           output int n_lb, output int n_den, output int n_rdy);
        lat = -1; zlat = -1; n_ce = 0; n_oe = 0; n_we = 0; n_ub = 0; n_lb = 0; n_den = 0; n_rdy = 0;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!mem_ce) n_ce++;
            if (!mem_oe) n_oe++;
            if (!mem_we) n_we++;
            if (!mem_ub) n_ub++;
            if (!mem_lb) n_lb++;
            if (mem_den) n_den++;
            if (ready) begin n_rdy++; if (lat < 0) lat = c; end
            if (z_ready && zlat < 0) zlat = c;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
        checks++; if ({mem_ce, mem_oe, mem_we, mem_ub, mem_lb} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes: got %b exp 11111", {mem_ce, mem_oe, mem_we, mem_ub, mem_lb}); end
        checks++; if (mem_den !== 1'b0) begin errors++; $display("FAIL reset_dout_en: got %b exp 0", mem_den); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h exp 0000", rdata); end
        checks++; if (hex !== {4{7'b1000000}}) begin errors++; $display("FAIL reset_hex: got %h exp %h", hex, {4{7'b1000000}}); end
        checks++; if ({mem_addr, mem_dout} !== 36'h0) begin errors++; $display("FAIL reset_bus: got %h/%h exp 0/0", mem_addr, mem_dout); end
        checks++; if ({z_mem_ce, z_mem_oe, z_mem_we, z_mem_ub, z_mem_lb, z_busy} !== 6'b111110) begin
            errors++; $display("FAIL reset_dut0: got %b exp 111110", {z_mem_ce, z_mem_oe, z_mem_we, z_mem_ub, z_mem_lb, z_busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sram_write();
        int lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy;
        run_txn(1'b1, 2'b11, 20'h00012, 16'hBEEF, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        ref_mem[18] = 16'hBEEF;
        checks++; if (lat !== WS + 3) begin errors++; $display("FAIL wr_latency: got %0d exp %0d", lat, WS + 3); end
        checks++; if (n_rdy !== 1) begin errors++; $display("FAIL wr_ready_count: got %0d exp 1", n_rdy); end
        checks++; if (n_we !== 3) begin errors++; $display("FAIL wr_we_cycles: got %0d exp 3", n_we); end
        checks++; if (n_ce !== 4) begin errors++; $display("FAIL wr_ce_cycles: got %0d exp 4", n_ce); end
        checks++; if ({n_ub, n_lb} !== {32'd4, 32'd4}) begin errors++; $display("FAIL wr_lanes: got ub %0d lb %0d exp 4 4", n_ub, n_lb); end
        checks++; if (n_den !== 5) begin errors++; $display("FAIL wr_dout_en: got %0d exp 5", n_den); end
        checks++; if (n_oe !== 0) begin errors++; $display("FAIL wr_oe: got %0d exp 0", n_oe); end
        checks++; if ({mem_addr, mem_dout} !== {20'h00012, 16'hBEEF}) begin
            errors++; $display("FAIL wr_bus_hold: got %h/%h exp 00012/beef", mem_addr, mem_dout); end
    endtask

    task automatic test_sram_read();
        int lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy;
        logic [15:0] e;
        run_txn(1'b0, 2'b10, 20'h00012, 16'h0000, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        e = ref_mem[18] & mask_of(2'b10);
        checks++; if ({n_ub, n_lb} !== {32'd4, 32'd0}) begin errors++; $display("FAIL rd_lanes: got ub %0d lb %0d exp 4 0", n_ub, n_lb); end
        checks++; if (n_oe !== 4) begin errors++; $display("FAIL rd_oe_cycles: got %0d exp 4", n_oe); end
        checks++; if (n_we + n_den !== 0) begin errors++; $display("FAIL rd_write_strobes: got %0d exp 0", n_we + n_den); end
        checks++; if (lat !== WS + 3) begin errors++; $display("FAIL rd_latency: got %0d exp %0d", lat, WS + 3); end
        checks++; if (rdata !== e) begin errors++; $display("FAIL rd_data: got %h exp %h", rdata, e); end
        checks++; if (z_rdata !== e) begin errors++; $display("FAIL rd_data_ws0: got %h exp %h", z_rdata, e); end
    endtask

    task automatic test_io_write();
        int lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy;
        run_txn(1'b1, 2'b11, IOA, 16'h1234, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        hex_model = 16'h1234;
        checks++; if (lat !== 1) begin errors++; $display("FAIL io_wr_latency: got %0d exp 1", lat); end
        checks++; if (n_ce + n_oe + n_we + n_ub + n_lb + n_den !== 0) begin
            errors++; $display("FAIL io_wr_strobes: got %0d exp 0", n_ce + n_oe + n_we + n_ub + n_lb + n_den); end
        checks++; if (hex !== exp_hex(hex_model)) begin errors++; $display("FAIL io_wr_hex1: got %h exp %h", hex, exp_hex(hex_model)); end
        run_txn(1'b1, 2'b01, IOA, 16'hABCD, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        hex_model = 16'h12CD;
        checks++; if (hex !== exp_hex(hex_model)) begin errors++; $display("FAIL io_wr_hex2: got %h exp %h", hex, exp_hex(hex_model)); end
        checks++; if (z_hex !== exp_hex(hex_model)) begin errors++; $display("FAIL io_wr_hex_ws0: got %h exp %h", z_hex, exp_hex(hex_model)); end
    endtask

    task automatic test_io_read();
        int lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy;
        switches = 16'h5A5A;
        repeat (3) @(negedge clk);
        run_txn(1'b0, 2'b11, IOA, 16'h0000, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        checks++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL io_rd_data: got %h exp 5a5a", rdata); end
        checks++; if (n_ce + n_oe !== 0) begin errors++; $display("FAIL io_rd_strobes: got %0d exp 0", n_ce + n_oe); end
        @(negedge clk);
        switches = 16'h1111;
        run_txn(1'b0, 2'b11, IOA, 16'h0000, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        checks++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL io_rd_sync_delay: got %h exp 5a5a", rdata); end
        run_txn(1'b0, 2'b01, IOA, 16'h0000, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        checks++; if (rdata !== 16'h0011) begin errors++; $display("FAIL io_rd_lane: got %h exp 0011", rdata); end
    endtask

    task automatic test_zero_wait();
        int lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy;
        run_txn(1'b0, 2'b11, 20'h00012, 16'h0000, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
        checks++; if (zlat !== 3) begin errors++; $display("FAIL ws0_latency: got %0d exp 3", zlat); end
        checks++; if (z_rdata !== ref_mem[18]) begin errors++; $display("FAIL ws0_data: got %h exp %h", z_rdata, ref_mem[18]); end
    endtask

    task automatic test_back_to_back();
        int t_d[$];
        int t_z[$];
        for (int ph = 0; ph < 2; ph++) begin
            t_d.delete(); t_z.delete();
            @(negedge clk);
            req = 1'b1; we = 1'b0; be = 2'b11; addr = (ph == 0) ? 20'h00012 : IOA;
            for (int c = 0; c < 60 && t_d.size() < 4; c++) begin
                @(negedge clk);
                if (ready) t_d.push_back(c);
                if (z_ready && t_z.size() < 4) t_z.push_back(c);
            end
            req = 1'b0;
            repeat (12) @(negedge clk);
            checks++; if (t_d.size() != 4 || t_z.size() != 4) begin
                errors++; $display("FAIL b2b_count_ph%0d: got %0d/%0d exp 4/4", ph, t_d.size(), t_z.size()); end
            else begin
                for (int i = 1; i < 4; i++) begin
                    checks++; if (t_d[i] - t_d[i-1] !== ((ph == 0) ? WS + 4 : 2)) begin
                        errors++; $display("FAIL b2b_spacing_ph%0d: got %0d exp %0d", ph, t_d[i] - t_d[i-1], (ph == 0) ? WS + 4 : 2); end
                    checks++; if (t_z[i] - t_z[i-1] !== ((ph == 0) ? 4 : 2)) begin
                        errors++; $display("FAIL b2b_spacing_ws0_ph%0d: got %0d exp %0d", ph, t_z[i] - t_z[i-1], (ph == 0) ? 4 : 2); end
                end
            end
        end
    endtask

    task automatic test_abort();
        int n_rdy;
        n_rdy = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 2'b11; addr = 20'd63; wdata = 16'($urandom);
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_pre_we: got %b exp 0", mem_we); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_we, mem_ce} !== 2'b11) begin errors++; $display("FAIL abort_strobes: got %b exp 11", {mem_we, mem_ce}); end
        checks++; if ({mem_den, busy} !== 2'b00) begin errors++; $display("FAIL abort_den_busy: got %b exp 00", {mem_den, busy}); end
        hex_model = '0;
        exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready) n_rdy++;
        end
        checks++; if (n_rdy !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d exp 0", n_rdy); end
        checks++; if (hex !== exp_hex(hex_model)) begin errors++; $display("FAIL abort_hex: got %h exp %h", hex, exp_hex(hex_model)); end
    endtask

    task automatic test_random();
        int lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy;
        int e_lat, e_zlat, e_ce, e_we;
        logic io, w;
        logic [1:0] b;
        logic [19:0] a;
        logic [15:0] d, sw, m;
        for (int it = 0; it < 40; it++) begin
            sw = 16'($urandom);
            switches = sw;
            repeat (2) @(negedge clk);
            io = ($urandom_range(0, 3) == 0);
            a  = io ? IOA : 20'($urandom_range(0, 62));
            w  = 1'($urandom_range(0, 1));
            b  = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            m  = mask_of(b);
            if (io || b == 2'b00) begin
                e_lat = 1; e_zlat = 1; e_ce = 0; e_we = 0;
                if (io && w) hex_model = (hex_model & ~m) | (d & m);
                else if (io) exp_rdata = sw & m;
            end else begin
                e_lat = WS + 3; e_zlat = 3; e_ce = WS + 2; e_we = w ? WS + 1 : 0;
                if (w) ref_mem[a[5:0]] = (ref_mem[a[5:0]] & ~m) | (d & m);
                else exp_rdata = ref_mem[a[5:0]] & m;
            end
            run_txn(w, b, a, d, lat, zlat, n_ce, n_oe, n_we, n_ub, n_lb, n_den, n_rdy);
            checks++; if (lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d exp %0d", it, lat, e_lat); end
            checks++; if (zlat !== e_zlat) begin errors++; $display("FAIL rnd%0d_latency_ws0: got %0d exp %0d", it, zlat, e_zlat); end
            checks++; if (n_rdy !== 1) begin errors++; $display("FAIL rnd%0d_ready_count: got %0d exp 1", it, n_rdy); end
            checks++; if (n_ce !== e_ce) begin errors++; $display("FAIL rnd%0d_ce: got %0d exp %0d", it, n_ce, e_ce); end
            checks++; if (n_we !== e_we) begin errors++; $display("FAIL rnd%0d_we: got %0d exp %0d", it, n_we, e_we); end
            checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h exp %h", it, rdata, exp_rdata); end
            checks++; if (z_rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata_ws0: got %h exp %h", it, z_rdata, exp_rdata); end
            checks++; if (hex !== exp_hex(hex_model)) begin errors++; $display("FAIL rnd%0d_hex: got %h exp %h", it, hex, exp_hex(hex_model)); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sram_write();
        test_sram_read();
        test_io_write();
        test_io_read();
        test_zero_wait();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
